fpu_decode_issue: RTL and testbench



---
 rtl/fpu_decode_issue.sv | 201 ++++++++++++++++++++
 tb/tb_fpu_decode_issue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_decode_issue.sv
// RV32F decode/issue stage: latches one FP instruction, decodes it to the FPU control code,
// counts the per-class execution latency and holds the result slot until writeback accepts it.
module fpu_decode_issue #(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 3,
  parameter int FMA_LAT  = 4,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [2:0]  frm,
  input  logic        flush,
  output logic        fpu_start,
  output logic [4:0]  fpu_ctrl,
  output logic [2:0]  rm_out,
  output logic [4:0]  rd_out,
  output logic        uses_rs3,
  output logic        reads_int,
  output logic        writes_int,
  output logic        illegal,
  output logic        busy,
  output logic        wb_valid,
  input  logic        wb_ready
);

  localparam int M1      = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int M2      = (FMA_LAT > DIV_LAT) ? FMA_LAT : DIV_LAT;
  localparam int M3      = (M1 > M2) ? M1 : M2;
  localparam int MAX_LAT = (M3 > SQRT_LAT) ? M3 : SQRT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d, lat_d;
  logic [4:0]         ctrl_d;
  logic [2:0]         rm_d, eff_rm;
  logic               ill_d, rs3_d, rdi_d, wri_d, use_rm, load, accept;

  logic [6:0] opcode, funct7;
  logic [4:0] rs2;
  logic [2:0] funct3;
  logic       unused_rs1;

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign rs2        = instr[24:20];
  assign funct7     = instr[31:25];
  assign unused_rs1 = ^instr[19:15];
  assign eff_rm     = (funct3 == 3'b111) ? frm : funct3;

  always_comb begin
    ctrl_d = 5'b00000;
    ill_d  = 1'b0;
    use_rm = 1'b0;
    rs3_d  = 1'b0;
    rdi_d  = 1'b0;
    wri_d  = 1'b0;
    lat_d  = CNT_W'(1);
    case (opcode)
      7'b1010011: begin
        case (funct7)
          7'b0000000: begin ctrl_d = 5'b00000; use_rm = 1'b1; lat_d = CNT_W'(ADD_LAT); end
          7'b0000100: begin ctrl_d = 5'b00001; use_rm = 1'b1; lat_d = CNT_W'(ADD_LAT); end
          7'b0001000: begin ctrl_d = 5'b00010; use_rm = 1'b1; lat_d = CNT_W'(MUL_LAT); end
          7'b0001100: begin ctrl_d = 5'b00011; use_rm = 1'b1; lat_d = CNT_W'(DIV_LAT); end
          7'b0101100: begin
            ctrl_d = 5'b00100; use_rm = 1'b1; lat_d = CNT_W'(SQRT_LAT);
            ill_d  = (rs2 != 5'd0);
          end
          7'b0010000: begin
            case (funct3)
              3'b000:  ctrl_d = 5'b00101;
              3'b001:  ctrl_d = 5'b00110;
              3'b010:  ctrl_d = 5'b00111;
              default: ill_d  = 1'b1;
            endcase
          end
          7'b0010100: begin
            lat_d = CNT_W'(ADD_LAT);
            case (funct3)
              3'b000:  ctrl_d = 5'b01011;
              3'b001:  ctrl_d = 5'b10011;
              default: ill_d  = 1'b1;
            endcase
          end
          7'b1010000: begin
            wri_d = 1'b1;
            case (funct3)
              3'b010:  ctrl_d = 5'b01000;
              3'b001:  ctrl_d = 5'b01001;
              3'b000:  ctrl_d = 5'b01010;
              default: ill_d  = 1'b1;
            endcase
          end
          7'b1100000: begin
            ctrl_d = {4'b0110, rs2[0]}; use_rm = 1'b1; wri_d = 1'b1;
            lat_d  = CNT_W'(ADD_LAT);
            ill_d  = (rs2[4:1] != 4'd0);
          end
          7'b1101000: begin
            ctrl_d = {4'b0111, rs2[0]}; use_rm = 1'b1; rdi_d = 1'b1;
            lat_d  = CNT_W'(ADD_LAT);
            ill_d  = (rs2[4:1] != 4'd0);
          end
          7'b1110000: begin
            wri_d = 1'b1;
            if (rs2 == 5'd0 && funct3 == 3'b000)      ctrl_d = 5'b10000;
            else if (rs2 == 5'd0 && funct3 == 3'b001) ctrl_d = 5'b10010;
            else                                      ill_d  = 1'b1;
          end
          7'b1111000: begin
            ctrl_d = 5'b10001; rdi_d = 1'b1;
            ill_d  = !(rs2 == 5'd0 && funct3 == 3'b000);
          end
          default: ill_d = 1'b1;
        endcase
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        // opcode[3:2] enumerates FMADD/FMSUB/FNMSUB/FNMADD in code order
        ctrl_d = {3'b101, opcode[3:2]}; use_rm = 1'b1; rs3_d = 1'b1;
        lat_d  = CNT_W'(FMA_LAT);
        ill_d  = (instr[26:25] != 2'b00);
      end
      default: ill_d = 1'b1;
    endcase
    rm_d = use_rm ? eff_rm : funct3;
    if (use_rm && (eff_rm inside {3'b101, 3'b110, 3'b111})) ill_d = 1'b1;
  end

  assign in_ready = rst && ((state == IDLE) || (state == WB && wb_ready)) && !flush;
  assign accept   = in_valid && in_ready;
  assign wb_valid = (state == WB);
  assign busy     = (state != IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    case (state)
      IDLE: load = accept;
      EXEC: begin
        if (cnt == CNT_W'(0)) state_d = IDLE;
        else begin
          cnt_d = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_d = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          if (accept) load = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = ill_d ? WB : EXEC;
      cnt_d   = ill_d ? CNT_W'(0) : lat_d;
    end
    if (flush) begin
      state_d = IDLE;
      cnt_d   = CNT_W'(0);
      load    = 1'b0;
    end
  end

  // accept edge: decode results become the held outputs of the op
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fpu_start  <= 1'b0;
      fpu_ctrl   <= '0;
      rm_out     <= '0;
      rd_out     <= '0;
      uses_rs3   <= 1'b0;
      reads_int  <= 1'b0;
      writes_int <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      fpu_start <= load && !ill_d;
      if (load) begin
        fpu_ctrl   <= ctrl_d;
        rm_out     <= rm_d;
        rd_out     <= instr[11:7];
        uses_rs3   <= rs3_d;
        reads_int  <= rdi_d;
        writes_int <= wri_d;
        illegal    <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_fpu_decode_issue.sv
// Bench for fpu_decode_issue: table of single-op vectors through a scoreboard queue,
// plus hand-written stall, back-to-back, flush and reset-mid-op sequences.
module tb_fpu_decode_issue;

  localparam int ADD_LAT  = 2;
  localparam int MUL_LAT  = 3;
  localparam int FMA_LAT  = 4;
  localparam int DIV_LAT  = 12;
  localparam int SQRT_LAT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [2:0]  frm = '0;
  logic        flush = 1'b0;
  logic        fpu_start;
  logic [4:0]  fpu_ctrl;
  logic [2:0]  rm_out;
  logic [4:0]  rd_out;
  logic        uses_rs3, reads_int, writes_int, illegal, busy, wb_valid;
  logic        wb_ready = 1'b1;

  fpu_decode_issue #(
    .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .FMA_LAT(FMA_LAT),
    .DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .frm(frm), .flush(flush), .fpu_start(fpu_start),
    .fpu_ctrl(fpu_ctrl), .rm_out(rm_out), .rd_out(rd_out),
    .uses_rs3(uses_rs3), .reads_int(reads_int), .writes_int(writes_int),
    .illegal(illegal), .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  frm;
    logic [4:0]  ctrl;
    logic [2:0]  rm;
    logic [4:0]  rd;
    logic        ill;
    logic        rs3;
    logic        rdi;
    logic        wri;
    int          wbc;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[18];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, 5'd1, f3, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] fma(input logic [6:0] op, input logic [1:0] fmt,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {5'd3, fmt, 5'd2, 5'd1, f3, rd, op};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic [2:0] fr, input logic [4:0] c,
                              input logic [2:0] rm, input logic ill, input logic rs3,
                              input logic rdi, input logic wri, input int wbc);
    vec_t v;
    v.instr = i; v.frm = fr; v.ctrl = c; v.rm = rm; v.rd = i[11:7];
    v.ill = ill; v.rs3 = rs3; v.rdi = rdi; v.wri = wri; v.wbc = wbc;
    return v;
  endfunction

  task automatic check_wb(input int cyc);
    vec_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("wb_cycle", cyc, e.wbc);
    chk("illegal", illegal, e.ill);
    if (!e.ill) begin
      chk("fpu_ctrl", fpu_ctrl, e.ctrl);
      chk("rm_out", rm_out, e.rm);
      chk("rd_out", rd_out, e.rd);
      chk("flags", {uses_rs3, reads_int, writes_int}, {e.rs3, e.rdi, e.wri});
    end
  endtask

  task automatic issue(input vec_t v);
    int cyc;
    int starts;
    chk("in_ready_idle", in_ready, 1);
    instr = v.instr; frm = v.frm; in_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1 in_valid = 1'b0;
    cyc = 1; starts = 0;
    @(negedge clk);
    chk("fpu_start_c1", fpu_start, !v.ill);
    while (!wb_valid && cyc < 64) begin
      starts += fpu_start;
      @(negedge clk);
      cyc++;
    end
    chk("fpu_start_pulses", starts, v.ill ? 0 : 1);
    chk("busy_wb", busy, 1);
    check_wb(cyc);
    @(negedge clk);
    chk("idle_after_wb", {busy, wb_valid}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int wbn;
    logic seen;
    vecs[0]  = mk(32'h00208053, 3'b000, 5'b00000, 3'b000, 0, 0, 0, 0, ADD_LAT + 1);
    vecs[1]  = mk(rt(7'b0000100, 5'd2, 3'b001, 5'd5), 3'b000, 5'b00001, 3'b001, 0, 0, 0, 0, ADD_LAT + 1);
    vecs[2]  = mk(rt(7'b0001000, 5'd2, 3'b111, 5'd3), 3'b001, 5'b00010, 3'b001, 0, 0, 0, 0, MUL_LAT + 1);
    vecs[3]  = mk(rt(7'b0001000, 5'd2, 3'b111, 5'd3), 3'b101, 5'b00010, 3'b000, 1, 0, 0, 0, 1);
    vecs[4]  = mk(rt(7'b0101100, 5'd3, 3'b000, 5'd4), 3'b000, 5'b00100, 3'b000, 1, 0, 0, 0, 1);
    vecs[5]  = mk(fma(7'b1000011, 2'b01, 3'b000, 5'd7), 3'b000, 5'b10100, 3'b000, 1, 0, 0, 0, 1);
    vecs[6]  = mk(fma(7'b1000011, 2'b00, 3'b000, 5'd7), 3'b000, 5'b10100, 3'b000, 0, 1, 0, 0, FMA_LAT + 1);
    vecs[7]  = mk(rt(7'b0010000, 5'd2, 3'b010, 5'd9), 3'b000, 5'b00111, 3'b010, 0, 0, 0, 0, 2);
    vecs[8]  = mk(rt(7'b0010100, 5'd2, 3'b001, 5'd10), 3'b000, 5'b10011, 3'b001, 0, 0, 0, 0, ADD_LAT + 1);
    vecs[9]  = mk(rt(7'b1100000, 5'd1, 3'b001, 5'd11), 3'b000, 5'b01101, 3'b001, 0, 0, 0, 1, ADD_LAT + 1);
    vecs[10] = mk(rt(7'b1101000, 5'd0, 3'b111, 5'd12), 3'b100, 5'b01110, 3'b100, 0, 0, 1, 0, ADD_LAT + 1);
    vecs[11] = mk(rt(7'b1111000, 5'd0, 3'b000, 5'd13), 3'b000, 5'b10001, 3'b000, 0, 0, 1, 0, 2);
    vecs[12] = mk(rt(7'b1110000, 5'd0, 3'b001, 5'd14), 3'b000, 5'b10010, 3'b001, 0, 0, 0, 1, 2);
    vecs[13] = mk(32'h0000A087, 3'b000, 5'b00000, 3'b000, 1, 0, 0, 0, 1);
    vecs[14] = mk(fma(7'b1001111, 2'b00, 3'b010, 5'd15), 3'b000, 5'b10111, 3'b010, 0, 1, 0, 0, FMA_LAT + 1);
    vecs[15] = mk(rt(7'b1010000, 5'd2, 3'b001, 5'd16), 3'b111, 5'b01001, 3'b001, 0, 0, 0, 1, 2);
    vecs[16] = mk(rt(7'b0001100, 5'd2, 3'b110, 5'd17), 3'b000, 5'b00011, 3'b110, 1, 0, 0, 0, 1);
    vecs[17] = mk(rt(7'b0010000, 5'd2, 3'b011, 5'd18), 3'b000, 5'b00000, 3'b000, 1, 0, 0, 0, 1);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {in_ready, fpu_start, fpu_ctrl, rm_out, rd_out, uses_rs3, reads_int,
                          writes_int, illegal, busy, wb_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) issue(vecs[i]);

    // FDIV with writeback stalled for cycles 13..15
    wb_ready = 1'b0;
    chk("in_ready_div", in_ready, 1);
    instr = rt(7'b0001100, 5'd2, 3'b000, 5'd20); frm = 3'b000; in_valid = 1'b1;
    sb.push_back(mk(instr, 3'b000, 5'b00011, 3'b000, 0, 0, 0, 0, DIV_LAT + 1));
    @(posedge clk); #1 in_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!wb_valid && cyc < 64) begin @(negedge clk); cyc++; end
    check_wb(cyc);
    for (int i = 0; i < 3; i++) begin
      chk("stall_wb_valid", wb_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_ctrl", {fpu_ctrl, rd_out}, {5'b00011, 5'd20});
      @(posedge clk);
    end
    #1 wb_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", {wb_valid, in_ready}, 2'b11);
    @(negedge clk);
    chk("stall_idle", {wb_valid, busy}, 2'b00);

    // back-to-back FMV.X.W then FEQ.S with in_valid held
    instr = rt(7'b1110000, 5'd0, 3'b000, 5'd4); in_valid = 1'b1;
    sb.push_back(mk(instr, 3'b000, 5'b10000, 3'b000, 0, 0, 0, 1, 2));
    sb.push_back(mk(rt(7'b1010000, 5'd2, 3'b010, 5'd6), 3'b000, 5'b01000, 3'b010, 0, 0, 0, 1, 4));
    @(posedge clk); #1 instr = rt(7'b1010000, 5'd2, 3'b010, 5'd6);
    wbn = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) in_valid = 1'b0;
      if (wb_valid) begin
        wbn++;
        check_wb(c);
      end
    end
    chk("b2b_wb_count", wbn, 2);

    // FSQRT flushed at cycle 5
    chk("in_ready_sqrt", in_ready, 1);
    instr = rt(7'b0101100, 5'd0, 3'b001, 5'd8); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {in_ready, busy}, 2'b01);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {busy, wb_valid}, 2'b00);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= wb_valid; end
    chk("flush_no_wb", seen, 0);

    // FSQRT reset at cycle 5
    instr = rt(7'b0101100, 5'd0, 3'b001, 5'd8); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    @(negedge clk);
    chk("rst_mid_outputs", {in_ready, fpu_start, fpu_ctrl, rm_out, rd_out, uses_rs3, reads_int,
                            writes_int, illegal, busy, wb_valid}, 32'd0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= wb_valid; end
    chk("rst_no_wb", seen, 0);

    issue(vecs[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
